bc_round_controller: RTL and testbench

//  Parametrised Bulls-and-Cows round engine: captures an N-digit guess from a one-hot 0-9 keypad,

---
 rtl/bc_pkg.sv | 28 ++
 rtl/bc_round_controller_if.sv | 35 +++
 rtl/bc_key_event.sv | 47 ++++
 rtl/bc_round_controller.sv | 221 ++++++++++++++++++++++
 tb/tb_bc_round_controller.sv | 381 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bc_pkg.sv
// Shared definitions for the Bulls-and-Cows round engine.
//   DIGIT_W / BLANK : BCD nibble width and the "position not entered" code
//   KEY_W           : keypad width, bit k = digit k
//   state_t         : round controller state encoding
//   onehot_to_bcd   : keypad level to BCD digit (lowest set bit wins if several are set)
package bc_pkg;
  localparam int DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] BLANK = 4'hF;
  localparam int KEY_W = 10;

  typedef enum logic [2:0] {
    S_NOSECRET = 3'd0,
    S_ENTRY    = 3'd1,
    S_SCORE    = 3'd2,
    S_RESULT   = 3'd3,
    S_WIN      = 3'd4,
    S_LOSE     = 3'd5
  } state_t;

  function automatic logic [DIGIT_W-1:0] onehot_to_bcd(input logic [KEY_W-1:0] k);
    logic [DIGIT_W-1:0] d;
    d = '0;
    for (int i = KEY_W - 1; i >= 0; i--) begin
      if (k[i]) d = DIGIT_W'(i);
    end
    return d;
  endfunction
endpackage

// File: rtl/bc_round_controller_if.sv
// Keypad / secret / result bundle between the keypad side (master) and the
// round controller (slave). i_* are inputs to the controller, o_* its outputs.
interface bc_round_controller_if
  import bc_pkg::*;
#(
  parameter int NUM_DIGITS = 4
);
  localparam int CNT_W = $clog2(NUM_DIGITS + 1);

  logic [KEY_W-1:0]              i_key;
  logic                          i_key_bksp;
  logic [DIGIT_W*NUM_DIGITS-1:0] i_secret_in;
  logic                          i_secret_load;
  logic [DIGIT_W*NUM_DIGITS-1:0] o_guess_disp;
  logic [CNT_W-1:0]              o_entry_cnt;
  logic [CNT_W-1:0]              o_strike;
  logic [CNT_W-1:0]              o_ball;
  logic                          o_score_valid;
  logic [7:0]                    o_tries_left;
  logic                          o_win;
  logic                          o_lose;
  logic                          o_entry_err;

  modport master (
    output i_key, i_key_bksp, i_secret_in, i_secret_load,
    input  o_guess_disp, o_entry_cnt, o_strike, o_ball, o_score_valid,
           o_tries_left, o_win, o_lose, o_entry_err
  );

  modport slave (
    input  i_key, i_key_bksp, i_secret_in, i_secret_load,
    output o_guess_disp, o_entry_cnt, o_strike, o_ball, o_score_valid,
           o_tries_left, o_win, o_lose, o_entry_err
  );
endinterface

// File: rtl/bc_key_event.sv
// Keypad press detector: one event per press on the rising edge of (|key) or
// key_bksp. Multi-key or key+backspace presses are flagged as bad events.
//   clk, rst     : clock, async active-high reset
//   i_key        : keypad level, i_key_bksp: backspace level
//   o_dig_evt    : clean digit press, o_digit its BCD value
//   o_bksp_evt   : clean backspace press
//   o_bad_evt    : rejected press
module bc_key_event
  import bc_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [KEY_W-1:0]   i_key,
  input  logic               i_key_bksp,
  output logic               o_dig_evt,
  output logic               o_bksp_evt,
  output logic               o_bad_evt,
  output logic [DIGIT_W-1:0] o_digit
);
  logic r_key_any;
  logic r_bksp_prev;
  logic w_key_any;
  logic w_evt;
  logic w_multi;
  logic w_bad;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_key_any   <= 1'b0;
      r_bksp_prev <= 1'b0;
    end else begin
      r_key_any   <= w_key_any;
      r_bksp_prev <= i_key_bksp;
    end
  end

  assign w_key_any = |i_key;
  assign w_evt     = (w_key_any & ~r_key_any) | (i_key_bksp & ~r_bksp_prev);
  // More than one bit set: clearing the lowest set bit leaves something behind.
  assign w_multi   = (i_key & (i_key - KEY_W'(1))) != '0;
  assign w_bad     = w_multi | (w_key_any & i_key_bksp);

  assign o_bad_evt  = w_evt & w_bad;
  assign o_dig_evt  = w_evt & ~w_bad & w_key_any;
  assign o_bksp_evt = w_evt & ~w_bad & ~w_key_any;
  assign o_digit    = onehot_to_bcd(i_key);
endmodule

// File: rtl/bc_round_controller.sv
// Bulls-and-Cows round engine: keypad guess entry with backspace and duplicate
// rejection, sequential strike/ball scoring (one guess digit per cycle), and a
// try budget ending in sticky win/lose.
//   clk, rst : clock, async active-high reset
//   bus      : keypad/secret inputs and guess/score/verdict outputs (slave side)
// Strike, ball, tries_left, win and lose all change together on the edge that
// opens RESULT, so every field is consistent while score_valid is high.
//
//   state    | meaning
//   NOSECRET | no secret loaded, presses rejected
//   ENTRY    | collecting guess digits
//   SCORE    | comparing guess digit r_idx against the secret
//   RESULT   | score_valid cycle, choose next round state
//   WIN      | guess matched, waiting for a new secret
//   LOSE     | tries exhausted, waiting for a new secret
module bc_round_controller
  import bc_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int MAX_TRIES    = 10,
  parameter int ALLOW_REPEAT = 0
) (
  input logic clk,
  input logic rst,
  bc_round_controller_if.slave bus
);
  localparam int CNT_W = $clog2(NUM_DIGITS + 1);
  localparam int SEC_W = DIGIT_W * NUM_DIGITS;

  state_t r_state, w_state_nxt;
  logic [SEC_W-1:0] r_secret, w_secret_nxt;
  logic [SEC_W-1:0] r_guess, w_guess_nxt;
  logic [CNT_W-1:0] r_entry_cnt, w_cnt_nxt;
  logic [CNT_W-1:0] r_strike, w_strike_nxt;
  logic [CNT_W-1:0] r_ball, w_ball_nxt;
  logic [CNT_W-1:0] r_idx, w_idx_nxt;
  logic [CNT_W-1:0] r_acc_s, w_acc_s_nxt;
  logic [CNT_W-1:0] r_acc_b, w_acc_b_nxt;
  logic [7:0]       r_tries_left, w_tries_nxt;
  logic             r_win, w_win_nxt;
  logic             r_lose, w_lose_nxt;
  logic             r_entry_err, w_err_nxt;

  logic               w_dig_evt, w_bksp_evt, w_bad_evt;
  logic [DIGIT_W-1:0] w_digit;
  logic               w_secret_ok, w_dup, w_hit, w_s_add, w_b_add;
  logic [DIGIT_W-1:0] w_g_cur, w_s_cur;
  logic [CNT_W-1:0]   w_strike_fin, w_ball_fin;

  bc_key_event u_key_event (
    .clk        (clk),
    .rst        (rst),
    .i_key      (bus.i_key),
    .i_key_bksp (bus.i_key_bksp),
    .o_dig_evt  (w_dig_evt),
    .o_bksp_evt (w_bksp_evt),
    .o_bad_evt  (w_bad_evt),
    .o_digit    (w_digit)
  );

  // Digit position p lives in nibble (NUM_DIGITS-1-p): digit 0 is the MS nibble.
  always_comb begin
    w_secret_ok = 1'b1;
    w_dup       = 1'b0;
    w_g_cur     = BLANK;
    w_s_cur     = BLANK;
    w_hit       = 1'b0;
    for (int p = 0; p < NUM_DIGITS; p++) begin
      if (bus.i_secret_in[(NUM_DIGITS-1-p)*DIGIT_W +: DIGIT_W] > 4'd9) w_secret_ok = 1'b0;
      if (r_guess[(NUM_DIGITS-1-p)*DIGIT_W +: DIGIT_W] == w_digit) w_dup = 1'b1;
      if (r_idx == CNT_W'(p)) begin
        w_g_cur = r_guess[(NUM_DIGITS-1-p)*DIGIT_W +: DIGIT_W];
        w_s_cur = r_secret[(NUM_DIGITS-1-p)*DIGIT_W +: DIGIT_W];
      end
    end
    // Only consulted when g[i] != s[i], so any match is necessarily at j != i.
    for (int j = 0; j < NUM_DIGITS; j++) begin
      if (r_secret[(NUM_DIGITS-1-j)*DIGIT_W +: DIGIT_W] == w_g_cur) w_hit = 1'b1;
    end
  end

  assign w_s_add      = (w_g_cur == w_s_cur);
  assign w_b_add      = ~w_s_add & w_hit;
  assign w_strike_fin = r_acc_s + CNT_W'(w_s_add);
  assign w_ball_fin   = r_acc_b + CNT_W'(w_b_add);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_NOSECRET;
      r_secret     <= '0;
      r_guess      <= {NUM_DIGITS{BLANK}};
      r_entry_cnt  <= '0;
      r_strike     <= '0;
      r_ball       <= '0;
      r_idx        <= '0;
      r_acc_s      <= '0;
      r_acc_b      <= '0;
      r_tries_left <= '0;
      r_win        <= 1'b0;
      r_lose       <= 1'b0;
      r_entry_err  <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_secret     <= w_secret_nxt;
      r_guess      <= w_guess_nxt;
      r_entry_cnt  <= w_cnt_nxt;
      r_strike     <= w_strike_nxt;
      r_ball       <= w_ball_nxt;
      r_idx        <= w_idx_nxt;
      r_acc_s      <= w_acc_s_nxt;
      r_acc_b      <= w_acc_b_nxt;
      r_tries_left <= w_tries_nxt;
      r_win        <= w_win_nxt;
      r_lose       <= w_lose_nxt;
      r_entry_err  <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_secret_nxt = r_secret;
    w_guess_nxt  = r_guess;
    w_cnt_nxt    = r_entry_cnt;
    w_strike_nxt = r_strike;
    w_ball_nxt   = r_ball;
    w_idx_nxt    = r_idx;
    w_acc_s_nxt  = r_acc_s;
    w_acc_b_nxt  = r_acc_b;
    w_tries_nxt  = r_tries_left;
    w_win_nxt    = r_win;
    w_lose_nxt   = r_lose;
    w_err_nxt    = 1'b0;

    if (bus.i_secret_load) begin
      if (w_secret_ok) begin
        w_secret_nxt = bus.i_secret_in;
        w_guess_nxt  = {NUM_DIGITS{BLANK}};
        w_cnt_nxt    = '0;
        w_tries_nxt  = 8'(MAX_TRIES);
        w_strike_nxt = '0;
        w_ball_nxt   = '0;
        w_win_nxt    = 1'b0;
        w_lose_nxt   = 1'b0;
        w_state_nxt  = S_ENTRY;
      end else begin
        w_err_nxt = 1'b1;
      end
    end else begin
      case (r_state)
        S_NOSECRET: begin
          if (w_dig_evt || w_bksp_evt || w_bad_evt) w_err_nxt = 1'b1;
        end
        S_ENTRY: begin
          if (w_bad_evt) begin
            w_err_nxt = 1'b1;
          end else if (w_dig_evt) begin
            if ((ALLOW_REPEAT == 0) && w_dup) begin
              w_err_nxt = 1'b1;
            end else begin
              for (int p = 0; p < NUM_DIGITS; p++) begin
                if (CNT_W'(p) == r_entry_cnt) w_guess_nxt[(NUM_DIGITS-1-p)*DIGIT_W +: DIGIT_W] = w_digit;
              end
              w_cnt_nxt = r_entry_cnt + CNT_W'(1);
              if (r_entry_cnt == CNT_W'(NUM_DIGITS - 1)) begin
                w_idx_nxt   = '0;
                w_acc_s_nxt = '0;
                w_acc_b_nxt = '0;
                w_state_nxt = S_SCORE;
              end
            end
          end else if (w_bksp_evt) begin
            if (r_entry_cnt == '0) begin
              w_err_nxt = 1'b1;
            end else begin
              for (int p = 0; p < NUM_DIGITS; p++) begin
                if (CNT_W'(p) == r_entry_cnt - CNT_W'(1)) w_guess_nxt[(NUM_DIGITS-1-p)*DIGIT_W +: DIGIT_W] = BLANK;
              end
              w_cnt_nxt = r_entry_cnt - CNT_W'(1);
            end
          end
        end
        S_SCORE: begin
          if (r_idx == CNT_W'(NUM_DIGITS - 1)) begin
            w_strike_nxt = w_strike_fin;
            w_ball_nxt   = w_ball_fin;
            w_tries_nxt  = r_tries_left - 8'd1;
            w_win_nxt    = (w_strike_fin == CNT_W'(NUM_DIGITS));
            w_lose_nxt   = (w_strike_fin != CNT_W'(NUM_DIGITS)) && (r_tries_left == 8'd1);
            w_state_nxt  = S_RESULT;
          end else begin
            w_acc_s_nxt = w_strike_fin;
            w_acc_b_nxt = w_ball_fin;
            w_idx_nxt   = r_idx + CNT_W'(1);
          end
        end
        S_RESULT: begin
          if (r_win) begin
            w_state_nxt = S_WIN;
          end else if (r_lose) begin
            w_state_nxt = S_LOSE;
          end else begin
            w_guess_nxt = {NUM_DIGITS{BLANK}};
            w_cnt_nxt   = '0;
            w_state_nxt = S_ENTRY;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.o_guess_disp  = r_guess;
  assign bus.o_entry_cnt   = r_entry_cnt;
  assign bus.o_strike      = r_strike;
  assign bus.o_ball        = r_ball;
  assign bus.o_score_valid = (r_state == S_RESULT);
  assign bus.o_tries_left  = r_tries_left;
  assign bus.o_win         = r_win;
  assign bus.o_lose        = r_lose;
  assign bus.o_entry_err   = r_entry_err;
endmodule

// File: tb/tb_bc_round_controller.sv
module tb_bc_round_controller;
  import bc_pkg::*;

  localparam int N    = 4;
  localparam int MAXA = 10;
  localparam int MAXB = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  tb_key;
  logic        tb_bksp;
  logic [15:0] tb_secret;
  logic        tb_load;

  always #5 clk = ~clk;

  bc_round_controller_if #(.NUM_DIGITS(N)) ifa ();
  bc_round_controller_if #(.NUM_DIGITS(N)) ifb ();

  assign ifa.i_key         = tb_key;
  assign ifa.i_key_bksp    = tb_bksp;
  assign ifa.i_secret_in   = tb_secret;
  assign ifa.i_secret_load = tb_load;
  assign ifb.i_key         = tb_key;
  assign ifb.i_key_bksp    = tb_bksp;
  assign ifb.i_secret_in   = tb_secret;
  assign ifb.i_secret_load = tb_load;

  bc_round_controller #(.NUM_DIGITS(N), .MAX_TRIES(MAXA), .ALLOW_REPEAT(0)) u_dut_a (
    .clk (clk), .rst (rst), .bus (ifa)
  );
  bc_round_controller #(.NUM_DIGITS(N), .MAX_TRIES(MAXB), .ALLOW_REPEAT(0)) u_dut_b (
    .clk (clk), .rst (rst), .bus (ifb)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model of DUT A at press/round granularity
  bit m_has;
  int m_sec[N];
  int m_g[$];
  int m_tries;
  bit m_win, m_lose;
  int m_strike, m_ball;
  bit chk_b;
  bit last_err;

  typedef struct {
    logic [15:0] secret;
    logic [15:0] guess;
    int          strike;
    int          ball;
    bit          win;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] disp();
    logic [15:0] d;
    d = 16'hFFFF;
    for (int i = 0; i < m_g.size(); i++) d[(N-1-i)*4 +: 4] = 4'(m_g[i]);
    return d;
  endfunction

  task automatic model_reset();
    m_has = 0; m_g.delete(); m_tries = 0;
    m_win = 0; m_lose = 0; m_strike = 0; m_ball = 0;
    for (int i = 0; i < N; i++) m_sec[i] = 0;
  endtask

  task automatic check_state();
    chk("guess_disp", 32'(ifa.o_guess_disp), 32'(disp()));
    chk("entry_cnt", 32'(ifa.o_entry_cnt), m_g.size());
    chk("tries_left", 32'(ifa.o_tries_left), m_tries);
    chk("win", 32'(ifa.o_win), 32'(m_win));
    chk("lose", 32'(ifa.o_lose), 32'(m_lose));
    chk("strike", 32'(ifa.o_strike), m_strike);
    chk("ball", 32'(ifa.o_ball), m_ball);
  endtask

  task automatic score();
    int c, s, b;
    bit f;
    c = 1;
    while (ifa.o_score_valid !== 1'b1 && c < 4 * N + 10) begin
      step();
      c++;
    end
    chk("score latency", c, N + 1);
    s = 0; b = 0;
    for (int i = 0; i < N; i++) begin
      if (m_g[i] == m_sec[i]) s++;
      else begin
        f = 0;
        for (int j = 0; j < N; j++) if (m_g[i] == m_sec[j]) f = 1;
        if (f) b++;
      end
    end
    m_strike = s; m_ball = b; m_tries--;
    m_win  = (s == N);
    m_lose = !m_win && (m_tries == 0);
    chk("score_valid", 32'(ifa.o_score_valid), 1);
    chk("score strike", 32'(ifa.o_strike), s);
    chk("score ball", 32'(ifa.o_ball), b);
    chk("score tries", 32'(ifa.o_tries_left), m_tries);
    chk("score win", 32'(ifa.o_win), 32'(m_win));
    chk("score lose", 32'(ifa.o_lose), 32'(m_lose));
    if (chk_b) begin
      chk("B score_valid", 32'(ifb.o_score_valid), 1);
      chk("B lose", 32'(ifb.o_lose), 1);
    end
    if (!m_win && !m_lose) m_g.delete();
    step();
    chk("score_valid pulse", 32'(ifa.o_score_valid), 0);
    check_state();
  endtask

  task automatic act_digit(input int d);
    bit exp_err, do_score, dup;
    exp_err = 0; do_score = 0;
    if (!m_has) exp_err = 1;
    else if (!(m_win || m_lose)) begin
      dup = 0;
      foreach (m_g[i]) if (m_g[i] == d) dup = 1;
      if (dup) exp_err = 1;
      else begin
        m_g.push_back(d);
        if (m_g.size() == N) do_score = 1;
      end
    end
    tb_key = 10'(1 << d);
    step();
    last_err = ifa.o_entry_err;
    chk("digit entry_err", 32'(ifa.o_entry_err), 32'(exp_err));
    tb_key = '0;
    if (do_score) score();
    else begin
      step();
      check_state();
    end
  endtask

  task automatic act_bksp();
    bit exp_err;
    exp_err = 0;
    if (!m_has) exp_err = 1;
    else if (!(m_win || m_lose)) begin
      if (m_g.size() == 0) exp_err = 1;
      else void'(m_g.pop_back());
    end
    tb_bksp = 1'b1;
    step();
    last_err = ifa.o_entry_err;
    chk("bksp entry_err", 32'(ifa.o_entry_err), 32'(exp_err));
    tb_bksp = 1'b0;
    step();
    check_state();
  endtask

  task automatic act_multi(input logic [9:0] k, input bit with_bksp);
    bit exp_err;
    exp_err = !m_has || !(m_win || m_lose);
    tb_key  = k;
    tb_bksp = with_bksp;
    step();
    last_err = ifa.o_entry_err;
    chk("multi entry_err", 32'(ifa.o_entry_err), 32'(exp_err));
    tb_key  = '0;
    tb_bksp = 1'b0;
    step();
    check_state();
  endtask

  task automatic act_load(input logic [15:0] s);
    bit ok;
    ok = 1;
    for (int i = 0; i < N; i++) if (s[(N-1-i)*4 +: 4] > 4'd9) ok = 0;
    if (ok) begin
      m_has = 1;
      for (int i = 0; i < N; i++) m_sec[i] = int'(s[(N-1-i)*4 +: 4]);
      m_g.delete(); m_tries = MAXA;
      m_win = 0; m_lose = 0; m_strike = 0; m_ball = 0;
    end
    tb_secret = s;
    tb_load   = 1'b1;
    step();
    last_err = ifa.o_entry_err;
    chk("load entry_err", 32'(ifa.o_entry_err), 32'(!ok));
    tb_load = 1'b0;
    step();
    check_state();
  endtask

  task automatic enter_guess(input logic [15:0] g);
    logic [15:0] gv;
    gv = g;
    for (int i = 0; i < N; i++) act_digit(int'(gv[(N-1-i)*4 +: 4]));
  endtask

  function automatic logic [15:0] rand_secret(input bit valid);
    logic [15:0] s;
    int p;
    for (int i = 0; i < N; i++) s[i*4 +: 4] = 4'($urandom_range(0, 9));
    if (!valid) begin
      p = $urandom_range(0, N - 1);
      s[p*4 +: 4] = 4'($urandom_range(10, 15));
    end
    return s;
  endfunction

  function automatic logic [9:0] two_bits();
    int a, b;
    a = $urandom_range(0, 9);
    b = (a + $urandom_range(1, 9)) % 10;
    return 10'((1 << a) | (1 << b));
  endfunction

  initial begin
    #500000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int cnt_sv, r;
    vecs[0] = '{16'h1234, 16'h1234, 4, 0, 1'b1};
    vecs[1] = '{16'h1234, 16'h4321, 0, 4, 1'b0};
    vecs[2] = '{16'h1234, 16'h1243, 2, 2, 1'b0};
    vecs[3] = '{16'h1234, 16'h5678, 0, 0, 1'b0};
    vecs[4] = '{16'h1234, 16'h1567, 1, 0, 1'b0};
    vecs[5] = '{16'h5678, 16'h8765, 0, 4, 1'b0};
    vecs[6] = '{16'h9012, 16'h9021, 2, 2, 1'b0};
    vecs[7] = '{16'h3456, 16'h3457, 3, 0, 1'b0};
    vecs[8] = '{16'h1123, 16'h1234, 1, 2, 1'b0};

    chk_b = 0;
    tb_key = '0; tb_bksp = 1'b0; tb_secret = '0; tb_load = 1'b0;
    rst = 1'b1;
    model_reset();
    repeat (3) step();
    rst = 1'b0;
    step();
    check_state();
    chk("reset secret reg", 32'(u_dut_a.r_secret), 0);
    chk("reset score_valid", 32'(ifa.o_score_valid), 0);
    chk("reset entry_err", 32'(ifa.o_entry_err), 0);

    // presses before any secret are rejected
    act_digit(1);
    act_bksp();

    // scoring table
    foreach (vecs[k]) begin
      act_load(vecs[k].secret);
      enter_guess(vecs[k].guess);
      chk("tbl strike", 32'(ifa.o_strike), vecs[k].strike);
      chk("tbl ball", 32'(ifa.o_ball), vecs[k].ball);
      chk("tbl win", 32'(ifa.o_win), 32'(vecs[k].win));
      chk("tbl tries", 32'(ifa.o_tries_left), 9);
    end

    // two guesses in one round
    act_load(16'h1234);
    enter_guess(16'h4321);
    chk("seq 4321 ball", 32'(ifa.o_ball), 4);
    enter_guess(16'h1243);
    chk("seq 1243 strike", 32'(ifa.o_strike), 2);
    chk("seq 1243 ball", 32'(ifa.o_ball), 2);
    chk("seq tries", 32'(ifa.o_tries_left), 8);

    // rst in the middle of scoring
    act_digit(5); act_digit(6); act_digit(7);
    tb_key = 10'(1 << 8);
    step();
    tb_key = '0;
    step();
    #2 rst = 1'b1;
    #1;
    chk("rst disp", 32'(ifa.o_guess_disp), 32'h0000FFFF);
    chk("rst entry_cnt", 32'(ifa.o_entry_cnt), 0);
    chk("rst tries", 32'(ifa.o_tries_left), 0);
    chk("rst strike", 32'(ifa.o_strike), 0);
    chk("rst ball", 32'(ifa.o_ball), 0);
    chk("rst score_valid", 32'(ifa.o_score_valid), 0);
    model_reset();
    step();
    rst = 1'b0;
    cnt_sv = 0;
    repeat (N + 3) begin
      step();
      if (ifa.o_score_valid) cnt_sv++;
    end
    chk("no score after rst", cnt_sv, 0);
    chk("rst secret reg", 32'(u_dut_a.r_secret), 0);
    check_state();

    // duplicate, multi-key, held key, backspace
    act_load(16'h1234);
    act_digit(9);
    act_multi(10'((1 << 3) | (1 << 7)), 1'b0);
    chk("multi err", 32'(last_err), 1);
    chk("multi disp", 32'(ifa.o_guess_disp), 32'h00009FFF);
    tb_key = 10'(1 << 6);
    repeat (5) step();
    tb_key = '0;
    step();
    m_g.push_back(6);
    chk("held cnt", 32'(ifa.o_entry_cnt), 2);
    chk("held disp", 32'(ifa.o_guess_disp), 32'h000096FF);
    act_multi(10'(1 << 2), 1'b1);
    act_bksp();
    act_bksp();
    act_bksp();
    chk("bksp at 0 err", 32'(last_err), 1);
    act_digit(5);
    act_digit(5);
    chk("dup err", 32'(last_err), 1);
    chk("dup cnt", 32'(ifa.o_entry_cnt), 1);
    act_bksp();

    // invalid secret leaves round untouched
    act_digit(1);
    act_load(16'h12A4);
    chk("bad secret err", 32'(last_err), 1);
    chk("bad secret disp", 32'(ifa.o_guess_disp), 32'h00001FFF);
    chk("bad secret reg", 32'(u_dut_a.r_secret), 32'h1234);
    act_digit(2); act_digit(3); act_digit(4);
    chk("after bad secret win", 32'(ifa.o_win), 1);

    // try budget of 2 on DUT B
    act_load(16'h1234);
    enter_guess(16'h5678);
    chk("B tries after 1", 32'(ifb.o_tries_left), 1);
    chk("B lose after 1", 32'(ifb.o_lose), 0);
    chk_b = 1;
    enter_guess(16'h8765);
    chk_b = 0;
    chk("B lose", 32'(ifb.o_lose), 1);
    chk("B tries", 32'(ifb.o_tries_left), 0);
    chk("A tries", 32'(ifa.o_tries_left), 8);
    act_digit(1);
    chk("B lose ignores keys", 32'(ifb.o_guess_disp), 32'h00008765);
    chk("B lose cnt", 32'(ifb.o_entry_cnt), 4);
    act_load(16'h5678);
    chk("B reload lose", 32'(ifb.o_lose), 0);
    chk("B reload tries", 32'(ifb.o_tries_left), 2);
    chk("B reload cnt", 32'(ifb.o_entry_cnt), 0);
    act_digit(3);
    chk("B entry after reload", 32'(ifb.o_guess_disp), 32'h00003FFF);

    // randomized play against the model
    for (int it = 0; it < 400; it++) begin
      r = $urandom_range(0, 99);
      if (!m_has || ((m_win || m_lose) && r < 60)) act_load(rand_secret(1'b1));
      else if (r < 65) act_digit($urandom_range(0, 9));
      else if (r < 78) act_bksp();
      else if (r < 84) act_multi(two_bits(), 1'b0);
      else if (r < 88) act_multi(10'(1 << $urandom_range(0, 9)), 1'b1);
      else if (r < 96) act_load(rand_secret(1'b1));
      else act_load(rand_secret(1'b0));
      repeat ($urandom_range(0, 2)) step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
